// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S frame geometry and bit-clock divider helper.
// Latency: n/a (constants and an elaboration-time function only).
// Backpressure: n/a.
package i2s_pkg;

   localparam int I2S_SLOT_BITS  = 32;
   localparam int I2S_FRAME_BITS = 64;

   // System-clock cycles per half bit-clock period (integer division).
   function automatic int half_div(input int clk_freq, input int i2s_clk_freq);
      return clk_freq / (2 * i2s_clk_freq);
   endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// i2s_rx_if: microphone-side I2S pins plus the PCM output strobe bundle.
// Latency: n/a (wiring only).
// Backpressure: none; the PCM consumer must take every pcm_ready strobe.
// Ports: master = receiver (drives clocks, strap and PCM; reads sd),
//        slave  = environment (microphone + PCM consumer).
interface i2s_rx_if #(
   parameter int DATA_OUT_SIZE = 24
);
   logic                     i2s_clk;
   logic                     i2s_ws;
   logic                     i2s_lr;
   logic                     i2s_sd;
   logic [DATA_OUT_SIZE-1:0] pcm_out;
   logic                     pcm_ready;

   modport master (
      output i2s_clk, i2s_ws, i2s_lr, pcm_out, pcm_ready,
      input  i2s_sd
   );

   modport slave (
      input  i2s_clk, i2s_ws, i2s_lr, pcm_out, pcm_ready,
      output i2s_sd
   );
endinterface

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: divides clk down to the I2S bit clock and flags its edges.
// Latency: strobes are combinational, high in the cycle whose clk edge toggles o_i2s_clk.
// Backpressure: none; free-running.
// Ports: clk/rst_n (sync, active-low), o_i2s_clk, o_rise_stb, o_fall_stb.
module i2s_clk_gen #(
   parameter int HALF_DIV = 33
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_i2s_clk,
   output logic o_rise_stb,
   output logic o_fall_stb
);
   localparam int DIV_W = $clog2(HALF_DIV);

   logic [DIV_W-1:0] r_div;
   logic             r_clk;
   logic             w_tc;

   assign w_tc = (r_div == DIV_W'(HALF_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div <= '0;
         r_clk <= 1'b0;
      end else if (w_tc) begin
         r_div <= '0;
         r_clk <= ~r_clk;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Strobe marks the cycle whose closing edge performs the toggle.
   assign o_rise_stb = w_tc & ~r_clk;
   assign o_fall_stb = w_tc &  r_clk;
   assign o_i2s_clk  = r_clk;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S mic receiver; deserialises one slot and averages REDUCE_FACTOR samples.
// Latency: pcm_ready/pcm_out update 2 clk after the rise_stb that captures the slot's last bit.
// Backpressure: none; pcm_out holds until the next strobe (at least one frame).
// Ports: clk, rst_n (sync, active-low), bus (i2s_rx_if.master: i2s_clk, i2s_ws,
//        i2s_lr, i2s_sd, pcm_out, pcm_ready).
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int I2S_CLK_FREQ  = 1_500_000,
   parameter int I2S_DATA_SIZE = 24,
   parameter int DATA_OUT_SIZE = 24,
   parameter int REDUCE_FACTOR = 2,
   parameter int CHANNEL       = 0
) (
   input  logic     clk,
   input  logic     rst_n,
   i2s_rx_if.master bus
);
   localparam int HALF_DIV = half_div(CLK_FREQ, I2S_CLK_FREQ);
   localparam int RED_LOG  = $clog2(REDUCE_FACTOR);
   localparam int ACC_W    = I2S_DATA_SIZE + RED_LOG;
   localparam int CNT_W    = RED_LOG + 1;
   localparam logic [5:0] C_FIRST = 6'(I2S_SLOT_BITS * CHANNEL + 1);
   localparam logic [5:0] C_LAST  = 6'(I2S_SLOT_BITS * CHANNEL + I2S_DATA_SIZE);

   if (HALF_DIV < 4) begin : g_bad_div
      $error("i2s_rx: CLK_FREQ/(2*I2S_CLK_FREQ) must be at least 4");
   end
   if (I2S_DATA_SIZE < 8 || I2S_DATA_SIZE > 31) begin : g_bad_ds
      $error("i2s_rx: I2S_DATA_SIZE must be 8..31");
   end
   if (REDUCE_FACTOR < 1 || REDUCE_FACTOR > 16 ||
       (REDUCE_FACTOR & (REDUCE_FACTOR - 1)) != 0) begin : g_bad_rf
      $error("i2s_rx: REDUCE_FACTOR must be a power of two in 1..16");
   end
   if (CHANNEL != 0 && CHANNEL != 1) begin : g_bad_ch
      $error("i2s_rx: CHANNEL must be 0 or 1");
   end

   logic w_i2s_clk;
   logic w_rise_stb;
   logic w_fall_stb;

   i2s_clk_gen #(.HALF_DIV(HALF_DIV)) u_clk_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .o_i2s_clk  (w_i2s_clk),
      .o_rise_stb (w_rise_stb),
      .o_fall_stb (w_fall_stb)
   );

   // ---------------- frame position / word select ----------------
   logic [5:0] r_bit_cnt;
   logic [5:0] w_bit_nxt;
   logic       r_ws;

   assign w_bit_nxt = r_bit_cnt + 6'd1;   // 6-bit wrap gives 63 -> 0

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
         r_ws      <= 1'b0;
      end else if (w_fall_stb) begin
         r_bit_cnt <= w_bit_nxt;
         r_ws      <= w_bit_nxt[5];       // upper half of the frame is the right slot
      end
   end

   // ---------------- serial data sync + deserialiser ----------------
   logic                     r_sd_meta;
   logic                     r_sd_sync;
   logic [I2S_DATA_SIZE-1:0] r_shift;
   logic                     r_done;
   logic                     w_in_slot;

   // Bit B of the slot is the I2S delay bit and is skipped.
   assign w_in_slot = (r_bit_cnt >= C_FIRST) && (r_bit_cnt <= C_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sd_meta <= 1'b0;
         r_sd_sync <= 1'b0;
         r_shift   <= '0;
         r_done    <= 1'b0;
      end else begin
         r_sd_meta <= bus.i2s_sd;
         r_sd_sync <= r_sd_meta;
         r_done    <= w_rise_stb && (r_bit_cnt == C_LAST);
         if (w_rise_stb && w_in_slot) begin
            r_shift <= {r_shift[I2S_DATA_SIZE-2:0], r_sd_sync};
         end
      end
   end

   // ---------------- decimator ----------------
   logic signed [ACC_W-1:0]         r_acc;
   logic        [CNT_W-1:0]         r_cnt;
   logic signed [ACC_W-1:0]         w_sample_ext;
   logic signed [ACC_W-1:0]         w_acc_sum;
   logic signed [I2S_DATA_SIZE-1:0] w_avg_ds;
   logic        [DATA_OUT_SIZE-1:0] w_aligned;
   logic        [DATA_OUT_SIZE-1:0] r_pcm;
   logic                            r_rdy;
   logic                            w_group_end;

   assign w_sample_ext = ACC_W'($signed(r_shift));
   assign w_acc_sum    = r_acc + w_sample_ext;
   // Arithmetic shift floors toward -inf; the mean always fits the slot width.
   assign w_avg_ds     = I2S_DATA_SIZE'(w_acc_sum >>> RED_LOG);
   assign w_group_end  = (r_cnt == CNT_W'(REDUCE_FACTOR - 1));

   if (I2S_DATA_SIZE < DATA_OUT_SIZE) begin : g_left_just
      assign w_aligned = {w_avg_ds, {(DATA_OUT_SIZE - I2S_DATA_SIZE){1'b0}}};
   end else if (I2S_DATA_SIZE > DATA_OUT_SIZE) begin : g_keep_msbs
      assign w_aligned = DATA_OUT_SIZE'(w_avg_ds >>> (I2S_DATA_SIZE - DATA_OUT_SIZE));
   end else begin : g_pass
      assign w_aligned = w_avg_ds;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_pcm <= '0;
         r_rdy <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         if (r_done) begin
            if (w_group_end) begin
               r_pcm <= w_aligned;
               r_rdy <= 1'b1;
               r_acc <= '0;
               r_cnt <= '0;
            end else begin
               r_acc <= w_acc_sum;
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign bus.i2s_clk   = w_i2s_clk;
   assign bus.i2s_ws    = r_ws;
   assign bus.i2s_lr    = (CHANNEL != 0);
   assign bus.pcm_out   = r_pcm;
   assign bus.pcm_ready = r_rdy;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: runs seven receiver configurations side by side against a frame-level model.
// Latency: expectations derived from cycle counts since reset release.
// Backpressure: n/a (bench).
module tb_i2s_rx;
   import i2s_pkg::*;

   localparam int NI         = 7;
   localparam int RUN_CYCLES = 9500;
   localparam int I2S_HZ     = 1_500_000;

   // Per-instance configuration table.
   function automatic int cfg_cf(input int i);
      return (i == 0) ? 100_000_000 : 12_000_000;
   endfunction
   function automatic int cfg_ds(input int i);
      case (i)
         3:       return 18;
         6:       return 8;
         default: return 24;
      endcase
   endfunction
   function automatic int cfg_out(input int i);
      case (i)
         5:       return 16;
         6:       return 8;
         default: return 24;
      endcase
   endfunction
   function automatic int cfg_rf(input int i);
      case (i)
         0:       return 2;
         2:       return 2;
         5:       return 4;
         6:       return 16;
         default: return 1;
      endcase
   endfunction
   function automatic int cfg_ch(input int i);
      case (i)
         4:       return 1;
         6:       return 1;
         default: return 0;
      endcase
   endfunction

   logic          clk = 1'b0;
   logic [NI-1:0] rst_n;
   logic [NI-1:0] sd;
   logic [NI-1:0] o_clk, o_ws, o_lr, o_rdy;
   logic [31:0]   o_pcm [NI];

   initial forever #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int OUT_W = cfg_out(gi);
      i2s_rx_if #(.DATA_OUT_SIZE(OUT_W)) bus ();
      i2s_rx #(
         .CLK_FREQ      (cfg_cf(gi)),
         .I2S_CLK_FREQ  (I2S_HZ),
         .I2S_DATA_SIZE (cfg_ds(gi)),
         .DATA_OUT_SIZE (OUT_W),
         .REDUCE_FACTOR (cfg_rf(gi)),
         .CHANNEL       (cfg_ch(gi))
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n[gi]),
         .bus   (bus)
      );
      assign bus.i2s_sd = sd[gi];
      assign o_clk[gi]  = bus.i2s_clk;
      assign o_ws[gi]   = bus.i2s_ws;
      assign o_lr[gi]   = bus.i2s_lr;
      assign o_rdy[gi]  = bus.pcm_ready;
      assign o_pcm[gi]  = 32'(bus.pcm_out);
   end

   int checks = 0;
   int errors = 0;

   // Model state per instance.
   longint      n     [NI];   // clk edges since reset release
   longint      acc   [NI];
   int          cnt   [NI];
   int          ep    [NI];   // reset epochs after the first run
   bit          ran   [NI];
   logic [31:0] exp_out [NI];
   bit          exp_rdy [NI];
   logic [31:0] cur_l [NI];
   logic [31:0] cur_r [NI];
   longint      mdl_first [NI][2];
   longint      dut_first [NI][2];
   int          rdy_cnt   [NI][2];
   longint      clk_rise0, ws_rise0, ws_rise1;
   bit          prev_clk0, prev_ws0;

   task automatic chk(input string name, input int inst, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, inst, $time, act, req);
      end
   endtask

   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint sext(input logic [31:0] w, input int ds);
      longint v;
      v = longint'(w) & ((longint'(1) << ds) - 1);
      if (w[ds-1]) v = v - (longint'(1) << ds);
      return v;
   endfunction

   function automatic logic [31:0] align(input longint avg, input int ds, input int outw);
      longint v;
      if (ds < outw)      v = avg * (longint'(1) << (outw - ds));
      else if (ds > outw) v = fdiv(avg, longint'(1) << (ds - outw));
      else                v = avg;
      return 32'(v & ((longint'(1) << outw) - 1));
   endfunction

   // Mic content for frame fr: directed words where the scenario needs them, random otherwise.
   task automatic pick_words(input int i, input longint fr);
      logic [31:0] mask;
      mask     = 32'((longint'(1) << cfg_ds(i)) - 1);
      cur_l[i] = $urandom & mask;
      cur_r[i] = $urandom & mask;
      case (i)
         1: if (fr < 3) begin cur_l[i] = 32'h123456; cur_r[i] = 32'hFFFFFF; end
         2: begin
            if (ep[i] == 0) begin
               case (fr)
                  0: cur_l[i] = 32'h000010;
                  1: cur_l[i] = 32'h000030;
                  2: cur_l[i] = 32'hFFFFF0;
                  3: cur_l[i] = 32'hFFFFE0;
                  default: ;
               endcase
            end else begin
               if (fr == 0) cur_l[i] = 32'hFFFFF0;
               if (fr == 1) cur_l[i] = 32'hFFFFE0;
            end
         end
         3: if (fr == 0) cur_l[i] = 32'h2ABCD;
         4: if (fr < 2) begin cur_l[i] = 32'h111111; cur_r[i] = 32'h222222; end
         default: ;
      endcase
   endtask

   task automatic step(input int i, input int cyc);
      longint hd, p, q, avg;
      int ds, outw, rf, ch, e;
      logic [31:0] w;
      hd   = longint'(half_div(cfg_cf(i), I2S_HZ));
      ds   = cfg_ds(i);
      outw = cfg_out(i);
      rf   = cfg_rf(i);
      ch   = cfg_ch(i);

      if (!rst_n[i]) begin
         if (ran[i]) begin ep[i]++; ran[i] = 1'b0; end
         n[i] = 0; acc[i] = 0; cnt[i] = 0; exp_out[i] = '0; exp_rdy[i] = 1'b0;
      end
      e = (ep[i] > 0) ? 1 : 0;
      if (rst_n[i]) begin
         ran[i]     = 1'b1;
         n[i]       = n[i] + 1;
         exp_rdy[i] = 1'b0;
         // Last slot bit is captured at the rising edge of bit period (32*ch+ds);
         // the averaged word is visible one clk edge after that i2s_clk rise.
         if (((n[i] - 1) % (128 * hd)) == 2 * hd * (32 * ch + ds) + hd) begin
            w       = (ch != 0) ? cur_r[i] : cur_l[i];
            acc[i] += sext(w, ds);
            cnt[i]++;
            if (cnt[i] == rf) begin
               avg        = fdiv(acc[i], rf);
               exp_out[i] = align(avg, ds, outw);
               exp_rdy[i] = 1'b1;
               acc[i]     = 0;
               cnt[i]     = 0;
               if (mdl_first[i][e] < 0) mdl_first[i][e] = longint'(exp_out[i]);
            end
         end
      end

      chk("i2s_clk",   i, 64'(o_clk[i]), 64'((n[i] / hd) % 2));
      chk("i2s_ws",    i, 64'(o_ws[i]),  64'(((n[i] / (2 * hd)) % 64) >= 32));
      chk("i2s_lr",    i, 64'(o_lr[i]),  64'(ch));
      chk("pcm_ready", i, 64'(o_rdy[i]), 64'(exp_rdy[i]));
      chk("pcm_out",   i, 64'(o_pcm[i]), 64'(exp_out[i]));

      if (o_rdy[i] === 1'b1) begin
         rdy_cnt[i][e]++;
         if (dut_first[i][e] < 0) dut_first[i][e] = longint'(o_pcm[i]);
      end
      if (i == 0 && e == 0 && rst_n[i]) begin
         if (o_clk[0] === 1'b1 && !prev_clk0 && clk_rise0 < 0) clk_rise0 = n[0];
         if (o_ws[0] === 1'b1 && !prev_ws0) begin
            if (ws_rise0 < 0)      ws_rise0 = n[0];
            else if (ws_rise1 < 0) ws_rise1 = n[0];
         end
         prev_clk0 = (o_clk[0] === 1'b1);
         prev_ws0  = (o_ws[0] === 1'b1);
      end

      // Microphone: new bit right after each falling bit-clock edge, one delay bit per slot.
      if ((n[i] % (2 * hd)) == 0) begin
         p = (n[i] / (2 * hd)) % 64;
         if (p == 0) pick_words(i, n[i] / (128 * hd));
         q = p % 32;
         w = (p >= 32) ? cur_r[i] : cur_l[i];
         if (q >= 1 && q <= ds) sd[i] = w[ds - int'(q)];
         else                   sd[i] = 1'($urandom_range(0, 1));
      end

      rst_n[i] = (cyc >= 3);
      // One-cycle reset at bit 10 of the second sample in the second group.
      if (i == 2 && ep[2] == 0 && rst_n[2] && n[2] == 3 * 128 * hd + 2 * hd * 10 + 1)
         rst_n[2] = 1'b0;
   endtask

   initial begin
      rst_n = '0;
      sd    = '0;
      clk_rise0 = -1; ws_rise0 = -1; ws_rise1 = -1;
      prev_clk0 = 1'b0; prev_ws0 = 1'b0;
      for (int i = 0; i < NI; i++) begin
         n[i] = 0; acc[i] = 0; cnt[i] = 0; ep[i] = 0; ran[i] = 1'b0;
         exp_out[i] = '0; exp_rdy[i] = 1'b0; cur_l[i] = '0; cur_r[i] = '0;
         for (int k = 0; k < 2; k++) begin
            mdl_first[i][k] = -1; dut_first[i][k] = -1; rdy_cnt[i][k] = 0;
         end
      end

      for (int cyc = 1; cyc <= RUN_CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) step(i, cyc);
      end

      // Clock/word-select timing at default parameters (HALF_DIV 33).
      chk("first_clk_rise", 0, 64'(clk_rise0), 64'd33);
      chk("first_ws_rise",  0, 64'(ws_rise0),  64'd2112);
      chk("ws_period",      0, 64'(ws_rise1 - ws_rise0), 64'd4224);
      // Model pinned to hand-computed results.
      chk("model_rf1",      1, 64'(mdl_first[1][0]), 64'h123456);
      chk("model_rf2_pos",  2, 64'(mdl_first[2][0]), 64'h000020);
      chk("model_rf2_neg",  2, 64'(mdl_first[2][1]), 64'hFFFFE8);
      chk("model_ds18",     3, 64'(mdl_first[3][0]), 64'hAAF340);
      chk("model_right",    4, 64'(mdl_first[4][0]), 64'h222222);
      // Same literals observed on the DUT.
      chk("dut_rf1",        1, 64'(dut_first[1][0]), 64'h123456);
      chk("dut_rf2_pos",    2, 64'(dut_first[2][0]), 64'h000020);
      chk("dut_after_rst",  2, 64'(dut_first[2][1]), 64'hFFFFE8);
      chk("dut_ds18",       3, 64'(dut_first[3][0]), 64'hAAF340);
      chk("dut_right",      4, 64'(dut_first[4][0]), 64'h222222);
      chk("aborted_group",  2, 64'(rdy_cnt[2][0]),   64'd1);
      chk("rf16_strobe",    6, 64'(rdy_cnt[6][0]),   64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S microphone receiver and decimator: generates the I2S bit clock and word select from the system clock, deserialises one channel slot of a standard 64-bit I2S frame, and averages every REDUCE_FACTOR samples into one PCM word. Sits directly upstream of the PCM-to-FIFO byte packer in the microphone capture top level and drives its pcm_out/pcm_ready inputs.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency, Hz.
- I2S_CLK_FREQ, 1_500_000: target bit-clock frequency, Hz.
- I2S_DATA_SIZE, 24: valid bits per slot, MSB first; range 8..31.
- DATA_OUT_SIZE, 24: pcm_out width.
- REDUCE_FACTOR, 2: samples averaged per output; power of two, 1..16.
- CHANNEL, 0: slot captured; 0 = left (ws low), 1 = right (ws high).
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; clock clk.
- i2s_clk  out  1  bit clock to microphone.
- i2s_ws  out  1  word select.
- i2s_lr  out  1  microphone channel strap, constant CHANNEL.
- i2s_sd  in  1  serial data from microphone, asynchronous.
- pcm_out  out  DATA_OUT_SIZE  averaged signed sample, held until next update.
- pcm_ready  out  1  one-cycle strobe, pcm_out new.

## Operation
- HALF_DIV = CLK_FREQ / (2*I2S_CLK_FREQ), integer division; elaboration error if < 4.
- Divider counter 0..HALF_DIV-1; on terminal count i2s_clk toggles. Toggle 0->1 raises rise_stb, 1->0 raises fall_stb, each for the same single cycle as the toggle.
- bit_cnt 0..63 increments on fall_stb, wraps 63->0. i2s_ws = (bit_cnt >= 32), registered.
- i2s_sd passes a 2-FF synchroniser; captured bit = synchronised value on rise_stb.
- Slot base B = 32*CHANNEL. Rise_stb with bit_cnt = B is the I2S delay bit, ignored. Rise_stb with bit_cnt = B+1..B+I2S_DATA_SIZE shifts bits into the sample register, MSB first. Other rising edges (incl. trailing zero bits, opposite slot) ignored.
- After the capture at bit_cnt = B+I2S_DATA_SIZE, the sample is complete: sign-extend to I2S_DATA_SIZE+log2(REDUCE_FACTOR) bits, add to accumulator, increment sample counter.
- When the counter reaches REDUCE_FACTOR: result = accumulator >>> log2(REDUCE_FACTOR) (arithmetic, truncation toward −inf); accumulator and counter clear for the next group; pcm_ready pulses.
- Width alignment: I2S_DATA_SIZE < DATA_OUT_SIZE -> left-justify, zero-fill LSBs; greater -> keep MSBs; equal -> pass through.
- REDUCE_FACTOR = 1: every sample emitted unmodified.
- No backpressure: downstream must accept each strobe; pcm_out is stable for at least one full frame.

## Timing
- Reset values: i2s_clk 0, i2s_ws 0, pcm_out 0, pcm_ready 0; divider, bit_cnt, shift register, accumulator, sample counter, synchroniser all 0. i2s_lr = CHANNEL always.
- First rise_stb HALF_DIV cycles after rst_n deasserts; bit period 2*HALF_DIV cycles; frame 128*HALF_DIV cycles.
- Complete-sample flag registered 1 cycle after the last capturing rise_stb; pcm_out/pcm_ready update 1 cycle later (latency 2 clk from last rise_stb).
- pcm_ready exactly 1 cycle high, once per REDUCE_FACTOR frames.
- Reset mid-frame: all state returns to reset values the next clock; the partial sample and the partial group are discarded; the first output after reset needs REDUCE_FACTOR complete new frames.
- i2s_ws transitions coincide with i2s_clk falling toggles only.

## Structure
- Package i2s_pkg: I2S_SLOT_BITS = 32, I2S_FRAME_BITS = 64, and the HALF_DIV helper function, shared with the top level and bench.
- Sub-module i2s_clk_gen: divider, i2s_clk register, rise_stb/fall_stb; the remaining logic (bit counter, deserialiser, decimator) stays in i2s_rx.

## Test plan
- Reset, default params (HALF_DIV 33): outputs all zero during reset; first i2s_clk rise at cycle 33; i2s_ws rises after 32 falls, period 4224 cycles.
- REDUCE_FACTOR=1: mic model drives 24'h123456 left, 24'hFFFFFF right -> pcm_out 24'h123456, one pcm_ready per frame, 2 cycles after last capture.
- REDUCE_FACTOR=2: 24'h000010 then 24'h000030 -> 24'h000020; 24'hFFFFF0 then 24'hFFFFE0 -> 24'hFFFFE8; one strobe per two frames.
- I2S_DATA_SIZE=18, DATA_OUT_SIZE=24: slot 18'h2ABCD -> pcm_out 24'hAAF340.
- CHANNEL=1: left 24'h111111, right 24'h222222 -> pcm_out 24'h222222; i2s_lr = 1.
- rst_n low for 1 cycle at bit_cnt 10 of second group sample: no pcm_ready for the aborted group; next output equals average of the two post-reset frames only.
